// File: rtl/rom_fetch_responder_if.sv
// rtl/rom_fetch_responder_if.sv - core fetch port and byte-wide instruction memory port
// The responder is the slave; the core/memory side drives the master modport.
interface rom_fetch_responder_if #(
  parameter int ADDR_W = 17
);
  logic              rom_ce_i;
  logic [31:0]       rom_addr_i;
  logic              inv_i;
  logic [31:0]       rom_data_o;
  logic              rom_ready_o;
  logic              mem_re_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [7:0]        mem_data_i;

  modport slave (
    input  rom_ce_i, rom_addr_i, inv_i, mem_data_i,
    output rom_data_o, rom_ready_o, mem_re_o, mem_addr_o
  );

  modport master (
    output rom_ce_i, rom_addr_i, inv_i, mem_data_i,
    input  rom_data_o, rom_ready_o, mem_re_o, mem_addr_o
  );
endinterface

// File: rtl/rom_fetch_responder.sv
// rtl/rom_fetch_responder.sv - instruction fetch responder with one-word buffer
// Assembles each 32-bit word from four little-endian byte reads of a synchronous memory.
module rom_fetch_responder #(
  parameter int          ADDR_W   = 17,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  rst,
  rom_fetch_responder_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t            r_state;
  logic [1:0]        r_cnt;
  logic [31:0]       r_buf;
  logic [29:0]       r_tag;
  logic              r_valid;
  logic              r_discard;
  logic [ADDR_W-3:0] r_base;
  logic [ADDR_W-1:0] r_mem_addr;

  state_t            w_state_nxt;
  logic [1:0]        w_cnt_nxt;
  logic [31:0]       w_buf_nxt;
  logic [29:0]       w_tag_nxt;
  logic              w_valid_nxt;
  logic              w_discard_nxt;
  logic [ADDR_W-3:0] w_base_nxt;
  logic              w_mem_re;
  logic [ADDR_W-1:0] w_mem_addr;
  logic              w_hit;
  logic              w_oor;
  logic              w_unused;

  assign w_hit    = bus.rom_ce_i & r_valid & (r_tag == bus.rom_addr_i[31:2]);
  assign w_oor    = |bus.rom_addr_i[31:ADDR_W];
  assign w_unused = &{1'b0, bus.rom_addr_i[1:0]};

  assign bus.rom_ready_o = w_hit;
  assign bus.rom_data_o  = r_buf;
  assign bus.mem_re_o    = w_mem_re;
  assign bus.mem_addr_o  = w_mem_addr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_buf_nxt     = r_buf;
    w_tag_nxt     = r_tag;
    w_valid_nxt   = r_valid;
    w_discard_nxt = r_discard;
    w_base_nxt    = r_base;
    w_mem_re      = 1'b0;
    w_mem_addr    = r_mem_addr;
    case (r_state)
      S_IDLE: begin
        if (bus.rom_ce_i && !w_hit) begin
          w_tag_nxt = bus.rom_addr_i[31:2];
          if (w_oor) begin
            w_buf_nxt   = NOP_INST;
            w_valid_nxt = 1'b1;
          end else begin
            w_base_nxt  = bus.rom_addr_i[ADDR_W-1:2];
            w_valid_nxt = 1'b0;
            w_cnt_nxt   = 2'd0;
            w_state_nxt = S_FETCH;
          end
        end
        if (bus.inv_i) begin
          w_valid_nxt = 1'b0;
        end
      end
      S_FETCH: begin
        w_mem_re   = 1'b1;
        w_mem_addr = {r_base, r_cnt};
        w_cnt_nxt  = r_cnt + 2'd1;
        // read data lags the strobe by one cycle, so this cycle returns byte cnt-1
        case (r_cnt)
          2'd1:    w_buf_nxt[7:0]   = bus.mem_data_i;
          2'd2:    w_buf_nxt[15:8]  = bus.mem_data_i;
          2'd3:    w_buf_nxt[23:16] = bus.mem_data_i;
          default: ;
        endcase
        if (r_cnt == 2'd3) begin
          w_state_nxt = S_DRAIN;
        end
        if (bus.inv_i) begin
          w_discard_nxt = 1'b1;
        end
      end
      S_DRAIN: begin
        w_buf_nxt[31:24] = bus.mem_data_i;
        w_valid_nxt      = !(r_discard || bus.inv_i);
        w_discard_nxt    = 1'b0;
        w_state_nxt      = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt      <= 2'd0;
      r_buf      <= 32'd0;
      r_tag      <= 30'd0;
      r_valid    <= 1'b0;
      r_discard  <= 1'b0;
      r_base     <= '0;
      r_mem_addr <= '0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_buf      <= w_buf_nxt;
      r_tag      <= w_tag_nxt;
      r_valid    <= w_valid_nxt;
      r_discard  <= w_discard_nxt;
      r_base     <= w_base_nxt;
      r_mem_addr <= w_mem_addr;
    end
  end

endmodule

// File: tb/tb_rom_fetch_responder.sv
// tb/tb_rom_fetch_responder.sv - scoreboard bench for rom_fetch_responder
module tb_rom_fetch_responder;
  localparam int ADDR_W = 17;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          re_count = 0;
  logic [7:0]  mem_q = 8'h00;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  rom_fetch_responder_if #(.ADDR_W(ADDR_W)) bus();

  rom_fetch_responder #(.ADDR_W(ADDR_W), .NOP_INST(32'h00000013)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [7:0] mem_byte(input logic [16:0] a);
    case (a)
      17'd0:   mem_byte = 8'h93;
      17'd1:   mem_byte = 8'h00;
      17'd2:   mem_byte = 8'h10;
      17'd3:   mem_byte = 8'h00;
      default: mem_byte = (a[7:0] * 8'd7) ^ a[15:8] ^ 8'h31;
    endcase
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] addr);
    logic [16:0] b;
    b = addr[16:0] & 17'h1fffc;
    return {mem_byte(b + 17'd3), mem_byte(b + 17'd2), mem_byte(b + 17'd1), mem_byte(b)};
  endfunction

  assign bus.mem_data_i = mem_q;

  always @(posedge clk) begin
    if (bus.mem_re_o === 1'b1) mem_q <= mem_byte(bus.mem_addr_o);
  end

  always @(posedge clk) begin
    if (bus.mem_re_o === 1'b1) re_count++;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.rom_ce_i = 1'b1;
    bus.rom_addr_i = 32'h0;
    bus.inv_i = 1'b0;
    step();
    step();
    checks++; if (bus.rom_data_o !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 00000000", bus.rom_data_o); end
    checks++; if (bus.rom_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus.rom_ready_o); end
    checks++; if (bus.mem_re_o !== 1'b0) begin errors++; $display("FAIL reset_re: got %b expected 0", bus.mem_re_o); end
    checks++; if (bus.mem_addr_o !== 17'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", bus.mem_addr_o); end
  endtask

  task automatic test_first_fetch();
    logic [31:0] exp;
    rst = 1'b1;
    sb.push_back(exp_word(32'h0));
    #1;
    checks++; if (bus.mem_re_o !== 1'b0 || bus.rom_ready_o !== 1'b0) begin errors++; $display("FAIL first_c0: got re=%b ready=%b expected 0/0", bus.mem_re_o, bus.rom_ready_o); end
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c <= 4) begin
        checks++; if (bus.mem_re_o !== 1'b1) begin errors++; $display("FAIL first_re c%0d: got %b expected 1", c, bus.mem_re_o); end
        checks++; if (bus.mem_addr_o !== 17'(c - 1)) begin errors++; $display("FAIL first_addr c%0d: got %h expected %h", c, bus.mem_addr_o, 17'(c - 1)); end
      end
      if (c == 5) begin
        checks++; if (bus.mem_re_o !== 1'b0) begin errors++; $display("FAIL first_re_drain: got %b expected 0", bus.mem_re_o); end
      end
      if (c < 6) begin
        checks++; if (bus.rom_ready_o !== 1'b0) begin errors++; $display("FAIL first_ready_early c%0d: got %b expected 0", c, bus.rom_ready_o); end
      end else begin
        checks++; if (bus.rom_ready_o !== 1'b1) begin errors++; $display("FAIL first_ready c6: got %b expected 1", bus.rom_ready_o); end
        exp = sb.pop_front();
        checks++; if (bus.rom_data_o !== exp) begin errors++; $display("FAIL first_data: got %h expected %h", bus.rom_data_o, exp); end
      end
    end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (bus.rom_ready_o !== 1'b1 || bus.mem_re_o !== 1'b0) begin errors++; $display("FAIL first_hold: got ready=%b re=%b expected 1/0", bus.rom_ready_o, bus.mem_re_o); end
    end
    checks++; if (re_count !== 4) begin errors++; $display("FAIL first_re_count: got %0d expected 4", re_count); end
  endtask

  task automatic test_sequential();
    logic [31:0] addrs[2];
    logic [31:0] exp;
    int base;
    int lat;
    addrs[0] = 32'h4;
    addrs[1] = 32'h8;
    for (int i = 0; i < 2; i++) begin
      base = re_count;
      sb.push_back(exp_word(addrs[i]));
      bus.rom_addr_i = addrs[i];
      #1;
      lat = 0;
      while (bus.rom_ready_o !== 1'b1 && lat < 20) begin step(); lat++; end
      checks++; if (lat != 6) begin errors++; $display("FAIL seq_latency %h: got %0d expected 6", addrs[i], lat); end
      exp = sb.pop_front();
      checks++; if (bus.rom_data_o !== exp) begin errors++; $display("FAIL seq_data %h: got %h expected %h", addrs[i], bus.rom_data_o, exp); end
      checks++; if (re_count - base != 4) begin errors++; $display("FAIL seq_reads %h: got %0d expected 4", addrs[i], re_count - base); end
    end
    base = re_count;
    sb.push_back(exp_word(32'h8));
    #1;
    checks++; if (bus.rom_ready_o !== 1'b1) begin errors++; $display("FAIL seq_hit_ready: got %b expected 1", bus.rom_ready_o); end
    exp = sb.pop_front();
    checks++; if (bus.rom_data_o !== exp) begin errors++; $display("FAIL seq_hit_data: got %h expected %h", bus.rom_data_o, exp); end
    step();
    step();
    checks++; if (re_count != base) begin errors++; $display("FAIL seq_hit_reads: got %0d expected %0d", re_count, base); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] exp;
    int base;
    int lat;
    base = re_count;
    sb.push_back(32'h00000013);
    bus.rom_addr_i = 32'h00020000;
    #1;
    lat = 0;
    while (bus.rom_ready_o !== 1'b1 && lat < 20) begin step(); lat++; end
    checks++; if (lat != 1) begin errors++; $display("FAIL oor_latency: got %0d expected 1", lat); end
    exp = sb.pop_front();
    checks++; if (bus.rom_data_o !== exp) begin errors++; $display("FAIL oor_data: got %h expected %h", bus.rom_data_o, exp); end
    step();
    step();
    checks++; if (re_count != base) begin errors++; $display("FAIL oor_reads: got %0d expected %0d", re_count, base); end
  endtask

  task automatic test_redirect();
    logic [31:0] exp;
    int base;
    base = re_count;
    bus.rom_addr_i = 32'h4;
    sb.push_back(exp_word(32'h40));
    #1;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 2) begin bus.rom_addr_i = 32'h40; #1; end
      if (c <= 4) begin
        checks++; if (bus.mem_re_o !== 1'b1 || bus.mem_addr_o !== 17'(3 + c)) begin errors++; $display("FAIL redir_old c%0d: got re=%b addr=%h expected 1/%h", c, bus.mem_re_o, bus.mem_addr_o, 17'(3 + c)); end
      end
      if (c == 7) begin
        checks++; if (bus.mem_re_o !== 1'b1 || bus.mem_addr_o !== 17'h40) begin errors++; $display("FAIL redir_new c7: got re=%b addr=%h expected 1/00040", bus.mem_re_o, bus.mem_addr_o); end
      end
      if (c < 12) begin
        checks++; if (bus.rom_ready_o !== 1'b0) begin errors++; $display("FAIL redir_ready_early c%0d: got %b expected 0", c, bus.rom_ready_o); end
      end else begin
        checks++; if (bus.rom_ready_o !== 1'b1) begin errors++; $display("FAIL redir_ready c12: got %b expected 1", bus.rom_ready_o); end
        exp = sb.pop_front();
        checks++; if (bus.rom_data_o !== exp) begin errors++; $display("FAIL redir_data: got %h expected %h", bus.rom_data_o, exp); end
      end
    end
    checks++; if (re_count - base != 8) begin errors++; $display("FAIL redir_reads: got %0d expected 8", re_count - base); end
  endtask

  task automatic test_invalidate();
    logic [31:0] exp;
    int lat;
    bus.rom_addr_i = 32'h8;
    sb.push_back(exp_word(32'h8));
    #1;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 3) bus.inv_i = 1'b1;
      if (c == 4) bus.inv_i = 1'b0;
      if (c == 6) begin
        checks++; if (bus.rom_ready_o !== 1'b0) begin errors++; $display("FAIL inv_discard c6: got %b expected 0", bus.rom_ready_o); end
      end
      if (c == 7) begin
        checks++; if (bus.mem_re_o !== 1'b1 || bus.mem_addr_o !== 17'h8) begin errors++; $display("FAIL inv_refetch c7: got re=%b addr=%h expected 1/00008", bus.mem_re_o, bus.mem_addr_o); end
      end
      if (c == 12) begin
        checks++; if (bus.rom_ready_o !== 1'b1) begin errors++; $display("FAIL inv_ready c12: got %b expected 1", bus.rom_ready_o); end
        exp = sb.pop_front();
        checks++; if (bus.rom_data_o !== exp) begin errors++; $display("FAIL inv_data: got %h expected %h", bus.rom_data_o, exp); end
      end
    end
    bus.inv_i = 1'b1;
    #1;
    checks++; if (bus.rom_ready_o !== 1'b1) begin errors++; $display("FAIL inv_hit_same: got %b expected 1", bus.rom_ready_o); end
    step();
    bus.inv_i = 1'b0;
    #1;
    checks++; if (bus.rom_ready_o !== 1'b0) begin errors++; $display("FAIL inv_hit_drop: got %b expected 0", bus.rom_ready_o); end
    sb.push_back(exp_word(32'h8));
    lat = 0;
    while (bus.rom_ready_o !== 1'b1 && lat < 20) begin step(); lat++; end
    checks++; if (lat != 6) begin errors++; $display("FAIL inv_relatency: got %0d expected 6", lat); end
    exp = sb.pop_front();
    checks++; if (bus.rom_data_o !== exp) begin errors++; $display("FAIL inv_redata: got %h expected %h", bus.rom_data_o, exp); end
  endtask

  task automatic test_reset_midfetch();
    logic [31:0] exp;
    int lat;
    bus.rom_addr_i = 32'h0;
    #1;
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == 3) rst = 1'b0;
    end
    checks++; if (bus.rom_data_o !== 32'h0 || bus.rom_ready_o !== 1'b0) begin errors++; $display("FAIL rst_mid_out: got data=%h ready=%b expected 00000000/0", bus.rom_data_o, bus.rom_ready_o); end
    checks++; if (bus.mem_re_o !== 1'b0 || bus.mem_addr_o !== 17'h0) begin errors++; $display("FAIL rst_mid_mem: got re=%b addr=%h expected 0/0", bus.mem_re_o, bus.mem_addr_o); end
    rst = 1'b1;
    sb.push_back(exp_word(32'h0));
    step();
    checks++; if (bus.mem_re_o !== 1'b1 || bus.mem_addr_o !== 17'h0) begin errors++; $display("FAIL rst_refetch: got re=%b addr=%h expected 1/0", bus.mem_re_o, bus.mem_addr_o); end
    lat = 1;
    while (bus.rom_ready_o !== 1'b1 && lat < 20) begin step(); lat++; end
    checks++; if (lat != 6) begin errors++; $display("FAIL rst_latency: got %0d expected 6", lat); end
    exp = sb.pop_front();
    checks++; if (bus.rom_data_o !== exp) begin errors++; $display("FAIL rst_data: got %h expected %h", bus.rom_data_o, exp); end
  endtask

  initial begin
    bus.rom_ce_i = 1'b0;
    bus.rom_addr_i = 32'h0;
    bus.inv_i = 1'b0;
    test_reset();
    test_first_fetch();
    test_sequential();
    test_out_of_range();
    test_redirect();
    test_invalidate();
    test_reset_midfetch();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_left: got %0d expected 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rom_fetch_responder.md
# rom_fetch_responder

Instruction-side memory responder for the `cpu` core. It answers the core's `rom_ce_o`/`rom_addr_o` fetch requests and returns 32-bit instructions on `rom_data_i`. It fetches each word as four little-endian bytes from a byte-wide synchronous instruction memory and keeps the last fetched word in a one-entry buffer. `rom_ready_o` feeds the IF stall request: the core stalls IF while ready is low.

## Interface
- `ADDR_W`, 17, byte-address width of the instruction memory; memory holds 2^(ADDR_W-2) words.
- `NOP_INST`, 32'h00000013, word returned for out-of-range addresses.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `rom_ce_i`  in  1  fetch request from the core.
- `rom_addr_i`  in  32  byte address of the fetch; bits [1:0] are ignored.
- `inv_i`  in  1  invalidate the word buffer (memory image changed).
- `rom_data_o`  out  32  buffered instruction word.
- `rom_ready_o`  out  1  `rom_data_o` is valid for the current `rom_addr_i`.
- `mem_re_o`  out  1  byte read strobe to the instruction memory.
- `mem_addr_o`  out  ADDR_W  byte address to the instruction memory.
- `mem_data_i`  in  8  read data; valid in the cycle after the `mem_re_o` cycle.

## Operation
- State: FSM {IDLE, FETCH, DRAIN}, 2-bit byte counter `cnt`, buffer word `buf`, tag `tag[31:2]`, `valid`.
- Hit is combinational: `hit = rom_ce_i & valid & (tag == rom_addr_i[31:2])`.
- `rom_ready_o = hit`.
- `rom_data_o = buf` at all times.
- **Out-of-range** means `rom_addr_i[31:ADDR_W] != 0`.
- **IDLE**, when `rom_ce_i & ~hit`:
  - If out-of-range: `buf<=NOP_INST`, `tag<=rom_addr_i[31:2]`, `valid<=1`. Stay in IDLE with no memory access.
  - Otherwise: latch `base<=rom_addr_i[ADDR_W-1:2]`, `tag<=rom_addr_i[31:2]`, `valid<=0`, `cnt<=0`, then go to FETCH.
- **FETCH**:
  - Outputs: `mem_re_o=1`, `mem_addr_o={base,cnt}`.
  - Each cycle `cnt` increments. From the second FETCH cycle onward, capture `mem_data_i` into byte `cnt-1` of `buf`.
  - After issuing `cnt==3`, go to DRAIN.
- **DRAIN**:
  - Outputs: `mem_re_o=0`.
  - Capture `mem_data_i` into `buf[31:24]`, set `valid<=1`, go to IDLE.
- Byte order is little-endian: byte at address `base*4+k` goes to `buf[8k+7:8k]`.
- A started fetch always runs to completion. A request change or `rom_ce_i` drop mid-fetch does not abort it. The new address misses in IDLE and starts a fresh fetch.
- `inv_i`:
  - In IDLE: clears `valid` at the next edge.
  - In FETCH/DRAIN: sets a sticky `discard` flag. DRAIN then leaves `valid=0` and clears `discard`.
  - Priority: `inv_i` beats the IDLE out-of-range load (valid stays 0 that edge).
- `mem_addr_o` holds its last value when `mem_re_o=0`.

## Timing
- Reset (`rst==0` at an edge) applies to the next cycle, from any state:
  - Control: state=IDLE, `cnt=0`, `valid=0`, `discard=0`.
  - Data: `buf=0`, `tag=0`, `base=0`.
  - Outputs: `rom_data_o=0`, `rom_ready_o=0`, `mem_re_o=0`, `mem_addr_o=0`.
- Reset mid-fetch abandons the fetch; the memory side needs no cleanup.
- **Miss latency.** Request first seen in IDLE at cycle T with a stable address:
  - FETCH runs cycles T+1..T+4, issuing bytes 0..3.
  - DRAIN runs at T+5.
  - `rom_ready_o=1` from T+6.
  - Total miss latency is 6 cycles.
- **Hit:** ready in the same cycle, zero latency. Back-to-back requests to the same word never touch memory.
- **Out-of-range:** ready at T+1 with `NOP_INST`.
- **Changed request during a fetch:** the fetch ends at T+5. At T+6 IDLE sees a miss and starts a new fetch.
- **Minimum cycles between consecutive miss fetches:** 6, since there is one IDLE cycle after DRAIN.

## Test plan
- Memory bytes 0x00..0x03 = 93,00,10,00. Hold `rom_ce_i=1`, `addr=0`, `rst` high from cycle 0. Expect:
  - `mem_re_o` high cycles 1–4 with `mem_addr_o` 0,1,2,3.
  - `rom_ready_o` rises at cycle 6 with `rom_data_o=0x00100093`.
  - Holding the request keeps ready high with no further `mem_re_o`.
- Sequential fetches at addr 0x0, 0x4, 0x8 with the core stalling on `!rom_ready_o`:
  - Each word takes 6 cycles.
  - Returned words match the memory image.
  - Re-requesting 0x8 hits immediately.
- Addr 0x00020000 with ADDR_W=17:
  - Ready at T+1 with `0x00000013`.
  - `mem_re_o` never asserted.
- Request 0x4, then switch to 0x40 at cycle T+2 (branch redirect):
  - The fetch of 0x4 completes.
  - `rom_ready_o` stays 0 (tag mismatch).
  - A new fetch of 0x40 starts at T+7, and ready asserts at T+12.
- `inv_i` pulse at T+3 during a fetch of 0x8:
  - `valid` stays 0 after DRAIN.
  - Refetch starts at T+7.
  - Later, an `inv_i` pulse while hitting drops ready the next cycle.
- `rst` driven low at T+3 mid-fetch:
  - Next cycle: all outputs zero and state IDLE.
  - After `rst` returns high, the same request refetches from byte 0 with 6-cycle latency.
